// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: per-boundary
// stall/flush strobes, fetch redirect for branches and traps, stall-cycle counter.
module pipeline_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_rs1_ren,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic                      id_rs2_ren,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      ex_is_load,
  input  logic                      ex_rw_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rw_addr,
  input  logic                      br_taken,
  input  logic [ADDR_WIDTH-1:0]     br_target,
  input  logic                      mem_busy,
  input  logic                      except_valid,
  input  logic [ADDR_WIDTH-1:0]     except_entry,
  input  logic                      ertn_valid,
  input  logic [ADDR_WIDTH-1:0]     ertn_pc,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      stall_ex,
  output logic                      stall_mem,
  output logic                      flush_if_id,
  output logic                      flush_id_ex,
  output logic                      flush_ex_mem,
  output logic                      flush_mem_wb,
  output logic                      redirect_valid,
  output logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] target_q;
  logic                  trap_c;
  logic                  load_use_c;
  logic                  any_stall_c;

  assign trap_c = except_valid | ertn_valid;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  always_comb begin
    load_use_c = 1'b0;
    if (ex_is_load && ex_rw_en && (ex_rw_addr != '0)) begin
      load_use_c = (id_rs1_ren && (id_rs1_addr == ex_rw_addr)) ||
                   (id_rs2_ren && (id_rs2_addr == ex_rw_addr));
    end
  end

  // Strobes are a pure function of state and this cycle's inputs.
  always_comb begin
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    flush_ex_mem   = 1'b0;
    flush_mem_wb   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!rst) begin
      case (state)
        REDIRECT: begin
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
          flush_if_id    = 1'b1;
        end
        RUN: begin
          if (trap_c) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
          end else if (mem_busy) begin
            // MEM is held while WB takes a bubble.
            stall_if     = 1'b1;
            stall_id     = 1'b1;
            stall_ex     = 1'b1;
            stall_mem    = 1'b1;
            flush_mem_wb = 1'b1;
          end else if (br_taken) begin
            redirect_valid = 1'b1;
            redirect_pc    = br_target;
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
          end else if (load_use_c) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign any_stall_c = stall_if | stall_id | stall_ex | stall_mem;

  // Trap target is captured in RUN and replayed for exactly one REDIRECT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      target_q  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (trap_c) begin
            target_q <= except_valid ? except_entry : ertn_pc;
            state    <= REDIRECT;
          end
        end
        REDIRECT: state <= RUN;
        default:  state <= RUN;
      endcase
      if (any_stall_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the five-stage pipeline (IF/ID/EX/MEM/WB).
- Generates per-boundary stall and flush strobes for the IF_ID, ID_EX, EX_MEM and MEM_WB registers, and a redirect request to fetch.
- Resolves load-use hazards, data-cache wait, EX branch redirects, and exception/ertn traps committed at MEM.
- Counts stall cycles for performance monitoring.

Parameters:
ADDR_WIDTH, 32, PC and redirect target width
REG_ADDR_WIDTH, 5, GPR index width
CNT_WIDTH, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1_ren  in  1  ID instruction reads rs1
id_rs1_addr  in  REG_ADDR_WIDTH  ID rs1 index
id_rs2_ren  in  1  ID instruction reads rs2
id_rs2_addr  in  REG_ADDR_WIDTH  ID rs2 index
ex_is_load  in  1  EX instruction is a load
ex_rw_en  in  1  EX instruction writes GPR
ex_rw_addr  in  REG_ADDR_WIDTH  EX destination index
br_taken  in  1  EX branch/jump resolved taken
br_target  in  ADDR_WIDTH  EX branch target
mem_busy  in  1  data cache/LSU not done for MEM instruction
except_valid  in  1  MEM instruction raises exception (valid instr only)
except_entry  in  ADDR_WIDTH  exception entry PC
ertn_valid  in  1  MEM instruction is ertn
ertn_pc  in  ADDR_WIDTH  ERA value
stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold that pipeline register
flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1 each  clear that pipeline register
redirect_valid  out  1  fetch must restart at redirect_pc
redirect_pc  out  ADDR_WIDTH  restart address
stall_cnt  out  CNT_WIDTH  cycles with any stall asserted

Behaviour:
- Two-state FSM: RUN, REDIRECT.
- Reset: state=RUN, latched target=0, stall_cnt=0; while rst=1, all strobes, redirect_valid and redirect_pc are 0.
- Outputs are combinational from state plus inputs; zero latency within the cycle.
- Priority in RUN, highest first: trap (except_valid, else ertn_valid), mem_busy, br_taken, load-use.
- Trap in RUN:
  - Same cycle: assert all four flush_*; all stalls 0.
  - Latch except_entry, or ertn_pc when only ertn_valid is set; except_valid wins when both are asserted.
  - Next state REDIRECT.
- REDIRECT (exactly 1 cycle):
  - redirect_valid=1, redirect_pc=latched target, flush_if_id=1.
  - All inputs ignored, including a new trap or br_taken.
  - Returns to RUN.
- mem_busy (no trap):
  - stall_if, stall_id, stall_ex, stall_mem = 1; flush_mem_wb=1 (bubble into WB).
  - br_taken and load-use are ignored this cycle; EX re-presents them once mem_busy drops.
- br_taken (no trap, no mem_busy):
  - redirect_valid=1, redirect_pc=br_target, flush_if_id=1, flush_id_ex=1.
  - Load-use is suppressed, because the ID instruction is wrong-path.
- Load-use hazard:
  - Condition: ex_is_load & ex_rw_en & ex_rw_addr!=0, and (id_rs1_ren & id_rs1_addr==ex_rw_addr) or (id_rs2_ren & id_rs2_addr==ex_rw_addr).
  - Response: stall_if=1, stall_id=1, flush_id_ex=1 (one bubble).
  - Rechecked every cycle; naturally clears after one cycle when the load advances.
- Index 0 never causes a hazard.
- stall_cnt increments by 1 in any cycle where any stall_* is 1 (rst=0); saturates at all-ones, never wraps.
- A stall and a flush on the same boundary never coexist, except flush_mem_wb with stall_mem during mem_busy. That pair is legal: MEM is held and WB receives a bubble.
- rst asserted mid-REDIRECT: FSM returns to RUN next edge, and no redirect is issued afterwards.

Test Plan:
- Load-use: ex_is_load=1, ex_rw_en=1, ex_rw_addr=5, id_rs2_ren=1, id_rs2_addr=5 -> stall_if=stall_id=flush_id_ex=1 for 1 cycle, stall_cnt 0->1. Repeat with ex_rw_addr=0 -> no stall.
- Branch: br_taken=1, br_target=0x1C000100 -> same cycle redirect_valid=1, redirect_pc=0x1C000100, flush_if_id=flush_id_ex=1; a concurrent load-use match is suppressed.
- Mem wait: mem_busy=1 for 3 cycles with br_taken=1 -> 3 cycles of all stalls plus flush_mem_wb, no redirect; the redirect fires the cycle mem_busy=0; stall_cnt +3.
- Trap: except_valid=1, ertn_valid=1, except_entry=0x1C008000, ertn_pc=0x1C000040 -> cycle0: all flushes; cycle1: redirect_valid=1, redirect_pc=0x1C008000, flush_if_id=1; cycle2: back in RUN, no outputs.
- REDIRECT ignores inputs: ertn_valid=1 in cycle0, then except_valid=1 and br_taken=1 in cycle1 -> cycle1 redirect_pc=ertn_pc only; cycle2 idle.
- Reset/saturation: preload stall_cnt to all-ones via long mem_busy (small CNT_WIDTH=4, 20 cycles) -> holds 15. rst during REDIRECT -> outputs 0, stall_cnt=0, no redirect after.
